// File: rtl/sevenseg_capture.sv
// Receive-side monitor for the multiplexed 4-digit active-low seven-segment bus.
// Optional feature: define SEVENSEG_CAPTURE_DP_EN to sample and decode the dp line.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 524288
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  input  logic       dp,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] code_err,
  output logic [1:0] dp_pos,
  output logic       dp_valid,
  output logic       frame_valid,
  output logic       locked
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam int unsigned SyncW = 12;
  logic [SyncW-1:0] pins;
  assign pins = {dp, an, seg};
`else
  localparam int unsigned SyncW = 11;
  logic [SyncW-1:0] pins;
  logic             unused_dp;
  assign pins      = {an, seg};
  assign unused_dp = dp;
`endif

  typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

  logic [SyncW-1:0] sync1_q, sync2_q;
  logic [CntW-1:0]  stable_cnt_q;
  logic [IdleW-1:0] idle_q;
  logic [3:0]       digit_q [4];
  logic [3:0]       code_err_q;
  logic [3:0]       seen_q;
  logic             dp_frame_q;
  logic [1:0]       dp_pos_q;
  logic             dp_valid_q;
  logic             frame_valid_q;
  lock_state_e      lock_q;

  logic [6:0] seg_s;
  logic [3:0] an_s;
  logic       dp_low;
  logic       strobe;
  logic       an_ok;
  logic [1:0] idx;
  logic [4:0] dec;
  logic       capture;
  logic [3:0] seen_upd;
  logic       frame_done;
  logic       dp_any;
  logic       expired;

  // Returns {err, value}; unknown patterns decode to value 0 with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0a;
      7'b0000011: r = 5'h0b;
      7'b1000110: r = 5'h0c;
      7'b0100001: r = 5'h0d;
      7'b0000110: r = 5'h0e;
      7'b0001110: r = 5'h0f;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  // Counter restarts on the same edge the second sync stage takes a new value, so it
  // always holds the number of cycles the synchronized vector has been unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_cnt_q <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      if (sync1_q != sync2_q) begin
        stable_cnt_q <= '0;
      end else if (stable_cnt_q != CntW'(STABLE_CYCLES)) begin
        stable_cnt_q <= stable_cnt_q + CntW'(1);
      end
    end
  end

  assign seg_s  = sync2_q[6:0];
  assign an_s   = sync2_q[10:7];
`ifdef SEVENSEG_CAPTURE_DP_EN
  assign dp_low = ~sync2_q[11];
`else
  assign dp_low = 1'b0;
`endif
  assign strobe = (stable_cnt_q == CntW'(STABLE_CYCLES - 1));

  always_comb begin
    an_ok = 1'b1;
    idx   = 2'd0;
    case (an_s)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      4'b1110: idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  assign dec        = decode_seg(seg_s);
  assign capture    = strobe & an_ok;
  assign seen_upd   = seen_q | (4'b0001 << idx);
  assign frame_done = capture & (seen_upd == 4'hf);
  assign dp_any     = dp_frame_q | dp_low;
  assign expired    = (idle_q == IdleW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q       <= '{default: '0};
      code_err_q    <= '0;
      seen_q        <= '0;
      dp_frame_q    <= 1'b0;
      dp_pos_q      <= '0;
      dp_valid_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      idle_q        <= '0;
    end else begin
      frame_valid_q <= frame_done;
      if (capture) begin
        digit_q[idx]    <= dec[3:0];
        code_err_q[idx] <= dec[4];
        idle_q          <= '0;
        if (dp_low) begin
          dp_pos_q <= ~idx;
        end
        if (frame_done) begin
          seen_q     <= '0;
          dp_frame_q <= 1'b0;
          dp_valid_q <= dp_any;
        end else begin
          seen_q     <= seen_upd;
          dp_frame_q <= dp_any;
        end
      end else if (expired) begin
        // Idle counter saturates here; the partial frame keeps being discarded.
        seen_q     <= '0;
        dp_frame_q <= 1'b0;
      end else begin
        idle_q <= idle_q + IdleW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= StUnlocked;
    end else begin
      case (lock_q)
        StUnlocked: if (frame_valid_q) lock_q <= StLocked;
        StLocked:   if (expired && !capture) lock_q <= StUnlocked;
        default:    lock_q <= StUnlocked;
      endcase
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign code_err    = code_err_q;
  assign dp_pos      = dp_pos_q;
  assign dp_valid    = dp_valid_q;
  assign frame_valid = frame_valid_q;
  assign locked      = (lock_q == StLocked);

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture: expected frames are queued as slots are driven
// and checked on each frame_valid pulse.
module tb_sevenseg_capture;

  localparam int unsigned S = 16;
  localparam int unsigned T = 600;
  localparam int unsigned H = 24;

  localparam logic [6:0] P0   = 7'b1000000;
  localparam logic [6:0] P1   = 7'b1111001;
  localparam logic [6:0] P2   = 7'b0100100;
  localparam logic [6:0] P3   = 7'b0110000;
  localparam logic [6:0] P4   = 7'b0011001;
  localparam logic [6:0] P5   = 7'b0010010;
  localparam logic [6:0] P6   = 7'b0000010;
  localparam logic [6:0] P7   = 7'b1111000;
  localparam logic [6:0] P8   = 7'b0000000;
  localparam logic [6:0] P9   = 7'b0010000;
  localparam logic [6:0] PA   = 7'b0001000;
  localparam logic [6:0] PB   = 7'b0000011;
  localparam logic [6:0] PC   = 7'b1000110;
  localparam logic [6:0] PD   = 7'b0100001;
  localparam logic [6:0] PE   = 7'b0000110;
  localparam logic [6:0] PF   = 7'b0001110;
  localparam logic [6:0] PBAD = 7'b0100011;

`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam logic [1:0] ExpDpPos = 2'b10;
  localparam logic       ExpDpVal = 1'b1;
`else
  localparam logic [1:0] ExpDpPos = 2'b00;
  localparam logic       ExpDpVal = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  err;
    logic [1:0]  dpp;
    logic        dpv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7f;
  logic [3:0] an = 4'hf;
  logic       dp = 1'b1;
  logic [3:0] digit0, digit1, digit2, digit3, code_err;
  logic [1:0] dp_pos;
  logic       dp_valid, frame_valid, locked;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_frames = 0;
  logic fv_prev = 1'b0;

  sevenseg_capture #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .code_err   (code_err),
    .dp_pos     (dp_pos),
    .dp_valid   (dp_valid),
    .frame_valid(frame_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; pins change now and are held for the given cycles.
  task automatic drive_slot(input logic [3:0] a, input logic [6:0] s, input logic d,
                            input int unsigned cycles);
    an  = a;
    seg = s;
    dp  = d;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check_eq("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check_eq("rst_code_err", code_err, 4'h0);
    check_eq("rst_dp_pos", dp_pos, 2'b00);
    check_eq("rst_dp_valid", dp_valid, 1'b0);
    check_eq("rst_frame_valid", frame_valid, 1'b0);
    check_eq("rst_locked", locked, 1'b0);
  endtask

  always @(negedge clk) begin
    if (fv_prev) begin
      check_eq("fv_one_cycle", frame_valid, 1'b0);
      check_eq("locked_after_fv", locked, 1'b1);
    end
    if (frame_valid) begin
      n_frames++;
      if (exp_q.size() == 0) begin
        check_eq("frame_unexpected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("fv_digits", {digit3, digit2, digit1, digit0}, mon_e.digits);
        check_eq("fv_code_err", code_err, mon_e.err);
        check_eq("fv_dp_pos", dp_pos, mon_e.dpp);
        check_eq("fv_dp_valid", dp_valid, mon_e.dpv);
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame 0,1,2,3
    exp_q.push_back(exp_t'{16'h3210, 4'h0, 2'b00, 1'b0});
    drive_slot(4'b0111, P0, 1'b1, H);
    drive_slot(4'b1011, P1, 1'b1, H);
    drive_slot(4'b1101, P2, 1'b1, H);
    drive_slot(4'b1110, P3, 1'b1, H);
    check_eq("locked_frame1", locked, 1'b1);

    // Glitching slot, then dp in slot 1 and an undecodable slot 2
    exp_q.push_back(exp_t'{16'hF075, 4'b0100, ExpDpPos, ExpDpVal});
    drive_slot(4'b0111, P8, 1'b1, 10);
    drive_slot(4'b0111, P3, 1'b1, 10);
    drive_slot(4'b0111, P8, 1'b1, 10);
    drive_slot(4'b0111, P3, 1'b1, 10);
    drive_slot(4'b0111, P5, 1'b1, S + 1);
    check_eq("glitch_no_capture", digit0, 4'h0);
    @(negedge clk);
    check_eq("glitch_capture_latency", digit0, 4'h5);
    repeat (4) @(negedge clk);
    drive_slot(4'b1011, P7, 1'b0, H);
    drive_slot(4'b1101, PBAD, 1'b1, H);
    check_eq("bad_digit2", digit2, 4'h0);
    check_eq("bad_code_err", code_err, 4'b0100);
    drive_slot(4'b1110, PF, 1'b1, H);

    // Two anodes low: ignored
    drive_slot(4'b0011, P8, 1'b1, H);
    check_eq("multi_an_d0", digit0, 4'h5);
    check_eq("multi_an_d1", digit1, 4'h7);

    // Recapture of index 3 overwrites; code_err clears
    exp_q.push_back(exp_t'{16'hDCBA, 4'h0, ExpDpPos, 1'b0});
    drive_slot(4'b1110, PE, 1'b1, H);
    drive_slot(4'b1101, PC, 1'b1, H);
    drive_slot(4'b1110, PD, 1'b1, H);
    drive_slot(4'b1011, PB, 1'b1, H);
    drive_slot(4'b0111, PA, 1'b1, H);

    // Timeout discards the partial frame
    drive_slot(4'b0111, P1, 1'b1, H);
    drive_slot(4'b1011, P2, 1'b1, H);
    drive_slot(4'b1111, 7'h7f, 1'b1, T - 40);
    check_eq("locked_before_timeout", locked, 1'b1);
    repeat (50) @(negedge clk);
    check_eq("locked_after_timeout", locked, 1'b0);
    drive_slot(4'b1101, P4, 1'b1, H);
    drive_slot(4'b1110, P6, 1'b1, H);
    drive_slot(4'b0111, P9, 1'b1, H);
    check_eq("no_frame_after_timeout", n_frames, 3);
    exp_q.push_back(exp_t'{16'h6489, 4'h0, ExpDpPos, 1'b0});
    drive_slot(4'b1011, P8, 1'b1, H);

    // Reset mid-frame
    drive_slot(4'b0111, P7, 1'b1, H);
    drive_slot(4'b1011, P2, 1'b1, H);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    drive_slot(4'b1101, P1, 1'b1, H);
    drive_slot(4'b1110, P7, 1'b1, H);
    drive_slot(4'b0111, P8, 1'b1, H);
    check_eq("no_frame_after_reset", n_frames, 4);
    exp_q.push_back(exp_t'{16'h71E8, 4'h0, 2'b00, 1'b0});
`ifdef SEVENSEG_CAPTURE_DP_EN
    drive_slot(4'b1011, PE, 1'b1, H);
`else
    an  = 4'b1011;
    seg = PE;
    for (int i = 0; i < 6; i++) begin
      dp = ~dp;
      repeat (3) @(negedge clk);
    end
    dp = 1'b1;
    repeat (10) @(negedge clk);
`endif
    repeat (5) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("frame_count", n_frames, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
